// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register: decodes the MIPS opcode/funct into the 4-bit ALU op
// and registers the operands, shift amount and EX/MEM/WB control bits, with stall and flush.
module id_ex_alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        flush,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rt_num,
  input  logic [4:0]  rd_num,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] pc_plus8,
  output logic [3:0]  ALUControl,
  output logic [31:0] reg_A,
  output logic [31:0] reg_B,
  output logic [4:0]  sa,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        valid_out,
  output logic        illegal_op
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_BEQ  = 4'b0011;
  localparam logic [3:0] ALU_BNE  = 4'b0100;
  localparam logic [3:0] ALU_SLLV = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRLV = 4'b1001;
  localparam logic [3:0] ALU_SRAV = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLL  = 4'b1101;
  localparam logic [3:0] ALU_SRL  = 4'b1110;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  sa;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        valid;
  } issue_t;

  issue_t      dec_s;
  issue_t      issue_r;
  logic        legal_s;
  logic        illegal_r;
  logic [31:0] imm_sext_s;
  logic [31:0] imm_zext_s;

  assign imm_sext_s = {{16{imm16[15]}}, imm16};
  assign imm_zext_s = {16'b0, imm16};

  // Decode the ID-stage instruction into a complete issue bundle (bubble if undecodable).
  always_comb begin
    dec_s   = '0;
    legal_s = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        dec_s.op_a      = rs_data;
        dec_s.op_b      = rt_data;
        dec_s.dest      = rd_num;
        dec_s.reg_write = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: dec_s.alu = ALU_ADD;
          FN_SUB, FN_SUBU: dec_s.alu = ALU_SUB;
          FN_AND:          dec_s.alu = ALU_AND;
          FN_OR:           dec_s.alu = ALU_OR;
          FN_XOR:          dec_s.alu = ALU_XOR;
          FN_NOR:          dec_s.alu = ALU_NOR;
          FN_SLT:          dec_s.alu = ALU_SLT;
          FN_SLTU:         dec_s.alu = ALU_SLTU;
          FN_SLL: begin
            dec_s.alu  = ALU_SLL;
            dec_s.op_a = 32'h0;
            dec_s.sa   = shamt;
          end
          FN_SRL: begin
            dec_s.alu  = ALU_SRL;
            dec_s.op_a = 32'h0;
            dec_s.sa   = shamt;
          end
          FN_SRA: begin
            dec_s.alu  = ALU_SRA;
            dec_s.op_a = 32'h0;
            dec_s.sa   = shamt;
          end
          // Variable shifts pass only the low five bits of rs as the amount.
          FN_SLLV: begin
            dec_s.alu  = ALU_SLLV;
            dec_s.op_a = {27'b0, rs_data[4:0]};
          end
          FN_SRLV: begin
            dec_s.alu  = ALU_SRLV;
            dec_s.op_a = {27'b0, rs_data[4:0]};
          end
          FN_SRAV: begin
            dec_s.alu  = ALU_SRAV;
            dec_s.op_a = {27'b0, rs_data[4:0]};
          end
          FN_JR: begin
            dec_s.alu       = ALU_ADD;
            dec_s.op_a      = 32'h0;
            dec_s.op_b      = 32'h0;
            dec_s.reg_write = 1'b0;
          end
          default: legal_s = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        dec_s.op_a      = rs_data;
        dec_s.op_b      = imm_sext_s;
        dec_s.dest      = rt_num;
        dec_s.reg_write = 1'b1;
        case (opcode)
          OP_SLTI:  dec_s.alu = ALU_SLT;
          OP_SLTIU: dec_s.alu = ALU_SLTU;
          OP_LW: begin
            dec_s.alu      = ALU_ADD;
            dec_s.mem_read = 1'b1;
          end
          default:  dec_s.alu = ALU_ADD;
        endcase
      end
      OP_SW: begin
        dec_s.alu       = ALU_ADD;
        dec_s.op_a      = rs_data;
        dec_s.op_b      = imm_sext_s;
        dec_s.mem_write = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_s.op_a      = rs_data;
        dec_s.op_b      = imm_zext_s;
        dec_s.dest      = rt_num;
        dec_s.reg_write = 1'b1;
        case (opcode)
          OP_ANDI: dec_s.alu = ALU_AND;
          OP_ORI:  dec_s.alu = ALU_OR;
          default: dec_s.alu = ALU_XOR;
        endcase
      end
      // lui is issued as a left shift of the zero-extended immediate by 16.
      OP_LUI: begin
        dec_s.alu       = ALU_SLL;
        dec_s.op_b      = imm_zext_s;
        dec_s.sa        = 5'd16;
        dec_s.dest      = rt_num;
        dec_s.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_s.alu  = (opcode == OP_BEQ) ? ALU_BEQ : ALU_BNE;
        dec_s.op_a = rs_data;
        dec_s.op_b = rt_data;
      end
      OP_J: begin
        dec_s.alu = ALU_ADD;
      end
      OP_JAL: begin
        dec_s.alu       = ALU_ADD;
        dec_s.op_a      = pc_plus8;
        dec_s.dest      = 5'd31;
        dec_s.reg_write = 1'b1;
      end
      default: legal_s = 1'b0;
    endcase
    dec_s.reg_write = dec_s.reg_write & (dec_s.dest != 5'd0);
    if (legal_s) begin
      dec_s.valid = 1'b1;
    end else begin
      dec_s = '0;
    end
  end

  // Pipeline register: reset > flush > stall (hold) > idle bubble > load decoded instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_r   <= '0;
      illegal_r <= 1'b0;
    end else if (flush) begin
      issue_r   <= '0;
      illegal_r <= 1'b0;
    end else if (stall) begin
      issue_r   <= issue_r;
      illegal_r <= 1'b0;
    end else if (!valid_in) begin
      issue_r   <= '0;
      illegal_r <= 1'b0;
    end else begin
      issue_r   <= dec_s;
      illegal_r <= ~legal_s;
    end
  end

  assign ALUControl = issue_r.alu;
  assign reg_A      = issue_r.op_a;
  assign reg_B      = issue_r.op_b;
  assign sa         = issue_r.sa;
  assign dest_reg   = issue_r.dest;
  assign reg_write  = issue_r.reg_write;
  assign mem_read   = issue_r.mem_read;
  assign mem_write  = issue_r.mem_write;
  assign valid_out  = issue_r.valid;
  assign illegal_op = illegal_r;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Self-checking bench for id_ex_alu_issue: decode vector table plus stall/flush/reset/illegal
// sequences, with expected bundles queued at drive time and popped after each clock edge.
module tb_id_ex_alu_issue;

  logic        clk;
  logic        reset, valid_in, stall, flush;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt, rt_num, rd_num;
  logic [15:0] imm16;
  logic [31:0] rs_data, rt_data, pc_plus8;
  logic [3:0]  ALUControl;
  logic [31:0] reg_A, reg_B;
  logic [4:0]  sa, dest_reg;
  logic        reg_write, mem_read, mem_write, valid_out, illegal_op;

  id_ex_alu_issue dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
    .opcode(opcode), .funct(funct), .shamt(shamt), .rt_num(rt_num), .rd_num(rd_num),
    .imm16(imm16), .rs_data(rs_data), .rt_data(rt_data), .pc_plus8(pc_plus8),
    .ALUControl(ALUControl), .reg_A(reg_A), .reg_B(reg_B), .sa(sa), .dest_reg(dest_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .valid_out(valid_out), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        v;
    logic        ill;
  } exp_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsd;
    logic        vin;
    exp_t        e;
  } vec_t;

  localparam logic [31:0] RSD = 32'h0000_0005;
  localparam logic [31:0] RTD = 32'hFFFF_FFF0;
  localparam logic [15:0] IMM = 16'h8001;
  localparam logic [31:0] PC8 = 32'h0040_0108;
  localparam logic [4:0]  SH  = 5'd3;
  localparam logic [31:0] SX  = 32'hFFFF_8001;
  localparam logic [31:0] ZX  = 32'h0000_8001;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t bubble   = '0;

  function automatic exp_t mk(input logic [3:0] alu, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] s, input logic [4:0] d, input logic rw,
                              input logic mr, input logic mw, input logic v, input logic ill);
    exp_t e;
    e = {alu, a, b, s, d, rw, mr, mw, v, ill};
    return e;
  endfunction

  task automatic add_vec(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                         input logic vin, input exp_t e);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.rt = rt; v.rd = rd; v.rsd = rsd; v.vin = vin; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v, input logic rst, input logic st, input logic fl, input exp_t e);
    reset = rst; stall = st; flush = fl;
    valid_in = v.vin; opcode = v.op; funct = v.fn; rt_num = v.rt; rd_num = v.rd; rs_data = v.rsd;
    exp_q.push_back(e);
  endtask

  task automatic cycle_check(input string nm);
    exp_t act, e;
    @(posedge clk);
    #1;
    act = {ALUControl, reg_A, reg_B, sa, dest_reg, reg_write, mem_read, mem_write, valid_out, illegal_op};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, no expected value queued", nm);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got alu=%h A=%h B=%h sa=%0d dest=%0d rw/mr/mw/v/ill=%b%b%b%b%b, want alu=%h A=%h B=%h sa=%0d dest=%0d rw/mr/mw/v/ill=%b%b%b%b%b",
                 nm, act.alu, act.a, act.b, act.sa, act.dest, act.rw, act.mr, act.mw, act.v, act.ill,
                 e.alu, e.a, e.b, e.sa, e.dest, e.rw, e.mr, e.mw, e.v, e.ill);
      end
    end
  endtask

  initial begin
    vec_t v_add, v_sub, v_xor, v_lw, v_bad;
    exp_t e_sub, e_xor, e_add;

    reset = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    opcode = 6'd0; funct = 6'd0; shamt = SH; rt_num = 5'd7; rd_num = 5'd9;
    imm16 = IMM; rs_data = RSD; rt_data = RTD; pc_plus8 = PC8;

    // name, opcode, funct, rt_num, rd_num, rs_data, valid_in, expected bundle
    add_vec("add",   6'b000000, 6'b100000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0010, RSD, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("addu",  6'b000000, 6'b100001, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0010, RSD, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("sub",   6'b000000, 6'b100010, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0110, RSD, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("subu",  6'b000000, 6'b100011, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0110, RSD, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("and",   6'b000000, 6'b100100, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0000, RSD, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("or",    6'b000000, 6'b100101, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0001, RSD, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("xor",   6'b000000, 6'b100110, 5'd7, 5'd9, RSD, 1'b1, mk(4'b1011, RSD, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("nor",   6'b000000, 6'b100111, 5'd7, 5'd9, RSD, 1'b1, mk(4'b1100, RSD, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("slt",   6'b000000, 6'b101010, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0111, RSD, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("sltu",  6'b000000, 6'b101011, 5'd7, 5'd9, RSD, 1'b1, mk(4'b1000, RSD, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("sll",   6'b000000, 6'b000000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b1101, 32'h0, RTD, SH, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("srl",   6'b000000, 6'b000010, 5'd7, 5'd9, RSD, 1'b1, mk(4'b1110, 32'h0, RTD, SH, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("sra",   6'b000000, 6'b000011, 5'd7, 5'd9, RSD, 1'b1, mk(4'b1111, 32'h0, RTD, SH, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("sllv",  6'b000000, 6'b000100, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0101, 32'h5, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("srlv",  6'b000000, 6'b000110, 5'd7, 5'd9, 32'hFFFF_FFE7, 1'b1, mk(4'b1001, 32'h7, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("srav",  6'b000000, 6'b000111, 5'd7, 5'd9, RSD, 1'b1, mk(4'b1010, 32'h5, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("jr",    6'b000000, 6'b001000, 5'd0, 5'd0, RSD, 1'b1, mk(4'b0010, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("addi",  6'b001000, 6'b100000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0010, RSD, SX, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("addiu", 6'b001001, 6'b111111, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0010, RSD, SX, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("slti",  6'b001010, 6'b000000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0111, RSD, SX, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("sltiu", 6'b001011, 6'b000000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b1000, RSD, SX, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("lw",    6'b100011, 6'b000000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0010, RSD, SX, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    add_vec("sw",    6'b101011, 6'b000000, 5'd0, 5'd0, RSD, 1'b1, mk(4'b0010, RSD, SX, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    add_vec("andi",  6'b001100, 6'b000000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0000, RSD, ZX, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("ori",   6'b001101, 6'b000000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0001, RSD, ZX, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("xori",  6'b001110, 6'b000000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b1011, RSD, ZX, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("lui",   6'b001111, 6'b000000, 5'd7, 5'd9, 32'h0, 1'b1, mk(4'b1101, 32'h0, ZX, 5'd16, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("beq",   6'b000100, 6'b000000, 5'd0, 5'd0, RSD, 1'b1, mk(4'b0011, RSD, RTD, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("bne",   6'b000101, 6'b000000, 5'd0, 5'd0, RSD, 1'b1, mk(4'b0100, RSD, RTD, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("j",     6'b000010, 6'b000000, 5'd0, 5'd0, RSD, 1'b1, mk(4'b0010, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("jal",   6'b000011, 6'b000000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0010, PC8, 32'h0, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("ill_op",6'b111111, 6'b100000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    add_vec("after_ill", 6'b000000, 6'b100000, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0010, RSD, RTD, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("ill_fn",6'b000000, 6'b111111, 5'd7, 5'd9, RSD, 1'b1, mk(4'b0000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    add_vec("ill_noval", 6'b111111, 6'b000000, 5'd7, 5'd9, RSD, 1'b0, bubble);
    add_vec("add_noval", 6'b000000, 6'b100000, 5'd7, 5'd9, RSD, 1'b0, bubble);
    add_vec("addu_r0",   6'b000000, 6'b100001, 5'd7, 5'd0, RSD, 1'b1, mk(4'b0010, RSD, RTD, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec("addi_r0",   6'b001000, 6'b000000, 5'd0, 5'd9, RSD, 1'b1, mk(4'b0010, RSD, SX, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    v_add = vecs[0]; v_sub = vecs[2]; v_xor = vecs[6]; v_lw = vecs[21]; v_bad = vecs[31];
    e_add = v_add.e; e_sub = v_sub.e; e_xor = v_xor.e;

    // Reset held two cycles with a valid add presented.
    drive(v_add, 1'b1, 1'b0, 1'b0, bubble); cycle_check("reset_1");
    drive(v_add, 1'b1, 1'b0, 1'b0, bubble); cycle_check("reset_2");

    foreach (vecs[i]) begin
      drive(vecs[i], 1'b0, 1'b0, 1'b0, vecs[i].e);
      cycle_check(vecs[i].name);
    end

    // Stall holds sub for three edges while ID presents xor.
    drive(v_sub, 1'b0, 1'b0, 1'b0, e_sub); cycle_check("stall_load_sub");
    for (int k = 0; k < 3; k++) begin
      drive(v_xor, 1'b0, 1'b1, 1'b0, e_sub); cycle_check("stall_hold");
    end
    drive(v_xor, 1'b0, 1'b0, 1'b0, e_xor); cycle_check("stall_release");

    // Stall with an illegal instruction in ID: hold, no pulse.
    drive(v_bad, 1'b0, 1'b1, 1'b0, e_xor); cycle_check("stall_ill_nopulse");

    // Flush overrides stall.
    drive(v_lw, 1'b0, 1'b1, 1'b1, bubble); cycle_check("flush_over_stall");

    // Flushed illegal instruction does not pulse.
    drive(v_bad, 1'b0, 1'b0, 1'b1, bubble); cycle_check("flush_ill");

    // Illegal pulse is not held across a following stall.
    drive(v_bad, 1'b0, 1'b0, 1'b0, vecs[31].e); cycle_check("ill_pulse");
    drive(v_add, 1'b0, 1'b1, 1'b0, bubble); cycle_check("ill_then_stall");

    // Reset mid-stall produces a bubble.
    drive(v_add, 1'b0, 1'b0, 1'b0, e_add); cycle_check("pre_reset_add");
    drive(v_add, 1'b1, 1'b1, 1'b0, bubble); cycle_check("reset_mid_stall");
    drive(v_add, 1'b0, 1'b1, 1'b0, bubble); cycle_check("stall_after_reset");
    drive(v_add, 1'b0, 1'b0, 1'b0, e_add); cycle_check("resume_add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
